// File: rtl/gold_seq_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the Gold sequence generator.
// The helpers precompute the x1 state and the x2 jump matrix after the NC-bit warm-up.
package gold_seq_pkg;

  localparam int GS_WIDTH = 31;
  localparam int GS_NC    = 1600;
  localparam int GS_OUT_W = 2;
  localparam int GS_LEN_W = 10;

  // x1: x^31+x^3+1, x2: x^31+x^3+x^2+x+1 (bit i of the mask taps state bit i)
  localparam logic [GS_WIDTH-1:0] X1_TAPS = 31'h0000_0009;
  localparam logic [GS_WIDTH-1:0] X2_TAPS = 31'h0000_000F;
  localparam logic [GS_WIDTH-1:0] X1_SEED = 31'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } gold_state_e;

  typedef logic [GS_WIDTH-1:0][GS_WIDTH-1:0] jump_mat_t;

  function automatic logic [GS_WIDTH-1:0] lfsr_step(input logic [GS_WIDTH-1:0] s,
                                                    input logic [GS_WIDTH-1:0] taps);
    return {^(s & taps), s[GS_WIDTH-1:1]};
  endfunction

  function automatic logic [GS_WIDTH-1:0] x1_at_nc();
    logic [GS_WIDTH-1:0] s;
    s = X1_SEED;
    for (int n = 0; n < GS_NC; n++) begin
      s = lfsr_step(s, X1_TAPS);
    end
    return s;
  endfunction

  // Column j is the x2 state reached after NC steps from the unit vector e_j.
  function automatic jump_mat_t x2_jump_matrix();
    jump_mat_t m;
    logic [GS_WIDTH-1:0] s;
    m = '0;
    for (int j = 0; j < GS_WIDTH; j++) begin
      s = '0;
      s[j] = 1'b1;
      for (int n = 0; n < GS_NC; n++) begin
        s = lfsr_step(s, X2_TAPS);
      end
      m[j] = s;
    end
    return m;
  endfunction

  function automatic logic [GS_WIDTH-1:0] x2_jump(input jump_mat_t m,
                                                  input logic [GS_WIDTH-1:0] s);
    logic [GS_WIDTH-1:0] acc;
    acc = '0;
    for (int j = 0; j < GS_WIDTH; j++) begin
      acc = acc ^ (m[j] & {GS_WIDTH{s[j]}});
    end
    return acc;
  endfunction

endpackage

// File: rtl/gold_lfsr_step.sv
// Combinational OUT_W-step unroll of one Fibonacci LFSR (shift right, feedback into MSB).
// bits[k] is state bit 0 before the k-th shift, so bit 0 is the earliest sequence bit.
module gold_lfsr_step #(
  parameter int               WIDTH = 31,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'd9),
  parameter int               OUT_W = 2
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out,
  output logic [OUT_W-1:0] bits
);

  logic [WIDTH-1:0] w_s;

  always_comb begin
    w_s  = state_in;
    bits = '0;
    for (int k = 0; k < OUT_W; k++) begin
      bits[k] = w_s[0];
      w_s     = {^(w_s & TAPS), w_s[WIDTH-1:1]};
    end
    state_out = w_s;
  end

endmodule

// File: rtl/gold_seq_gen.sv
// Gold sequence c(n) generator: discards NC warm-up bits, then streams OUT_W bits/word under valid/ready.
// Define GOLD_SEQ_JUMP_EN to replace the iterative warm-up with a single-cycle A^NC jump.
module gold_seq_gen
  import gold_seq_pkg::*;
#(
  parameter int WIDTH = GS_WIDTH,
  parameter int NC    = GS_NC,
  parameter int OUT_W = GS_OUT_W,
  parameter int LEN_W = GS_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] c_init,
  input  logic [LEN_W-1:0] len,
  output logic [OUT_W-1:0] out_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int WARM_W = $clog2(NC / OUT_W + 1);
  localparam int CNT_W  = (LEN_W > WARM_W) ? LEN_W : WARM_W;
`ifdef GOLD_SEQ_JUMP_EN
  localparam int                WARM_CYC = 1;
  localparam jump_mat_t         JUMP_M   = x2_jump_matrix();
  localparam logic [WIDTH-1:0]  X1_NC    = x1_at_nc();
`else
  localparam int                WARM_CYC = NC / OUT_W;
`endif

  gold_state_e      r_state;
  logic [WIDTH-1:0] r_x1;
  logic [WIDTH-1:0] r_x2;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_x1_adv;
  logic [WIDTH-1:0] w_x2_adv;
  logic [WIDTH-1:0] w_x1_warm;
  logic [WIDTH-1:0] w_x2_warm;
  logic [OUT_W-1:0] w_bits1;
  logic [OUT_W-1:0] w_bits2;
  logic             w_accept;
  logic             w_last;

  gold_lfsr_step #(.WIDTH(WIDTH), .TAPS(X1_TAPS), .OUT_W(OUT_W)) u_x1_step (
    .state_in  (r_x1),
    .state_out (w_x1_adv),
    .bits      (w_bits1)
  );

  gold_lfsr_step #(.WIDTH(WIDTH), .TAPS(X2_TAPS), .OUT_W(OUT_W)) u_x2_step (
    .state_in  (r_x2),
    .state_out (w_x2_adv),
    .bits      (w_bits2)
  );

`ifdef GOLD_SEQ_JUMP_EN
  assign w_x1_warm = X1_NC;
  assign w_x2_warm = x2_jump(JUMP_M, r_x2);
`else
  assign w_x1_warm = w_x1_adv;
  assign w_x2_warm = w_x2_adv;
`endif

  assign w_accept  = r_out_valid & out_ready;
  assign w_last    = (r_cnt + CNT_W'(32'd1)) == CNT_W'(r_len);

  // Bits are only meaningful while a word is offered; forced to 0 otherwise.
  assign out_bits  = r_out_valid ? (w_bits1 ^ w_bits2) : '0;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  // Sequencer FSM: start has priority over every state; r_cnt counts warm-up cycles, then words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_x1        <= X1_SEED;
      r_x2        <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_x1        <= X1_SEED;
        r_x2        <= c_init;
        r_cnt       <= '0;
        r_len       <= len;
        r_out_valid <= 1'b0;
        if (len == '0) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_state <= ST_WARM;
          r_busy  <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
          ST_WARM: begin
            if (r_cnt < CNT_W'(WARM_CYC)) begin
              r_x1  <= w_x1_warm;
              r_x2  <= w_x2_warm;
              r_cnt <= r_cnt + CNT_W'(32'd1);
            end else begin
              r_state     <= ST_RUN;
              r_out_valid <= 1'b1;
              r_cnt       <= '0;
            end
          end
          ST_RUN: begin
            if (w_accept) begin
              r_x1 <= w_x1_adv;
              r_x2 <= w_x2_adv;
              if (w_last) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_cnt       <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(32'd1);
              end
            end else begin
              r_cnt <= r_cnt;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gold_seq_gen.sv
// Scoreboard bench for gold_seq_gen: expected words come from the 36.211 recurrence on x1(n)/x2(n).
// Stimulus pushes expectations on start; a negedge monitor pops and compares every accepted word.
module tb_gold_seq_gen;

  localparam int NC_B = 1600;
`ifdef GOLD_SEQ_JUMP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 801;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [30:0] c_init;
  logic [9:0]  len;
  logic [1:0]  out_bits;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_vec   = 0;
  int n_err   = 0;
  int n_words = 0;
  int n_done  = 0;
  int n_valid = 0;

  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;
  logic       bp_mode    = 1'b0;
  logic [1:0] bp_idx     = 2'd0;
  logic [3:0] bp_pat     = 4'b1001;
  logic       prev_stall = 1'b0;
  logic [1:0] prev_bits  = 2'd0;

  always #5 clk = ~clk;

  gold_seq_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_init    (c_init),
    .len       (len),
    .out_bits  (out_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s at %0t", name, why, $time);
  endtask

  // Reference: x1(n+31)=x1(n+3)+x1(n), x2(n+31)=x2(n+3)+x2(n+2)+x2(n+1)+x2(n), c(n)=x1(n+NC)+x2(n+NC)
  task automatic push_expected(input logic [30:0] cinit, input int nw);
    bit         a [0:2047];
    bit         b [0:2047];
    logic [1:0] w;
    for (int n = 0; n < 31; n++) begin
      a[n] = (n == 0);
      b[n] = cinit[n];
    end
    for (int n = 0; n + 31 < NC_B + 2 * nw; n++) begin
      a[n+31] = a[n+3] ^ a[n];
      b[n+31] = b[n+3] ^ b[n+2] ^ b[n+1] ^ b[n];
    end
    for (int i = 0; i < nw; i++) begin
      w[0] = a[NC_B+2*i]   ^ b[NC_B+2*i];
      w[1] = a[NC_B+2*i+1] ^ b[NC_B+2*i+1];
      exp_q.push_back(w);
    end
  endtask

  task automatic start_seq(input logic [30:0] ci, input logic [9:0] l);
    @(posedge clk); #1;
    start  = 1'b1;
    c_init = ci;
    len    = l;
    @(posedge clk); #1;
    start  = 1'b0;
    exp_q.delete();
    push_expected(ci, int'(l));
  endtask

  task automatic check_latency(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_first_valid_latency"}, 32'(cyc), 32'(LAT));
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) fail_now({tag, "_wait_idle"}, "busy still high after cycle budget");
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_seq(input logic [30:0] ci, input logic [9:0] l, input string tag);
    int d0 = n_done;
    int w0 = n_words;
    start_seq(ci, l);
    check_latency(tag);
    wait_idle(tag);
    @(posedge clk); #1;
    chk({tag, "_words"}, 32'(n_words - w0), 32'(l));
    chk({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
  endtask

  // out_ready driver: always 1, or the 1,0,0,1 pattern while bp_mode is set
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        out_ready = bp_pat[bp_idx];
        bp_idx    = bp_idx + 2'd1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: counts valid/done cycles, checks hold under backpressure, pops on each accept
  always @(negedge clk) begin
    if (out_valid) n_valid++;
    if (done) n_done++;
    if (prev_stall && out_valid) chk("stall_hold", 32'(out_bits), 32'(prev_bits));
    if (out_valid && out_ready) begin
      n_words++;
      if (exp_q.size() == 0) begin
        fail_now("word", $sformatf("got %0h, want nothing (queue empty)", out_bits));
      end else begin
        mon_exp = exp_q.pop_front();
        chk("word", 32'(out_bits), 32'(mon_exp));
      end
    end
    prev_stall = out_valid && !out_ready && !start && rst;
    prev_bits  = out_bits;
  end

  initial begin
    int t_d0;
    int t_w0;
    int t_v0;
    int t;
    rst    = 1'b0;
    start  = 1'b0;
    c_init = 31'd0;
    len    = 10'd0;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_bits",  32'(out_bits),  32'd0);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_done",      32'(done),      32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_seq(31'h0000_0000, 10'd4, "t1");
    run_seq(31'h0000_1E5A, 10'd8, "t2");

    bp_mode = 1'b1;
    run_seq(31'h2B3C_4D5E, 10'd6, "t3");
    bp_mode = 1'b0;

    // Restart mid-RUN: old stream abandoned, new stream after a full warm-up, one done only
    t_d0 = n_done;
    start_seq(31'h0ABC_DEF1, 10'd10);
    check_latency("t4a");
    t_w0 = n_words;
    t = 0;
    while (n_words < t_w0 + 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (n_words < t_w0 + 3) fail_now("t4_words_before_restart", "fewer than 3 words accepted");
    start_seq(31'h3141_5926, 10'd5);
    chk("t4_valid_drop", 32'(out_valid), 32'd0);
    check_latency("t4b");
    wait_idle("t4");
    @(posedge clk); #1;
    chk("t4_done_pulses", 32'(n_done - t_d0), 32'd1);

    // len == 0: immediate done, never valid
    t_d0 = n_done;
    t_v0 = n_valid;
    start_seq(31'h0000_0007, 10'd0);
    chk("t5_done_next", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("t5_done_single", 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_valid_never", 32'(n_valid - t_v0), 32'd0);
    chk("t5_done_count", 32'(n_done - t_d0), 32'd1);

    // Asynchronous reset in the middle of warm-up
    t_d0 = n_done;
    start_seq(31'h0000_0005, 10'd3);
    repeat (LAT / 2) @(posedge clk);
    chk("t5_warm_busy", 32'(busy), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("t5_rst_busy",      32'(busy),      32'd0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_out_bits",  32'(out_bits),  32'd0);
    chk("t5_rst_done",      32'(done),      32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("t5_rst_no_done", 32'(n_done - t_d0), 32'd0);

    run_seq(31'h0000_002A, 10'd2, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
